count_snapshot_tx: RTL

- Downstream consumer of the dual 64-bit event counter block.
- On a snapshot request, atomically latches both counter values (counter 0 and counter 1).
- Streams them out as a framed byte sequence over a valid/ready interface: header, counter 0, counter 1, checksum.
- Feeds the debug/trace byte link, so software reads both counts as one coherent pair.

---
 rtl/count_snapshot_tx.sv | 114 +++++++++++
 1 files changed

// File: rtl/count_snapshot_tx.sv
// Snapshot transmitter: latches two counters atomically on Snap and streams
// header, counter 0, counter 1 (MSB-first) and an XOR checksum as one byte frame.
module count_snapshot_tx #(
  parameter int          CNT_W    = 64,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [CNT_W-1:0] Cnt0,
  input  logic [CNT_W-1:0] Cnt1,
  input  logic             Snap,
  output logic [7:0]       TxData,
  output logic             TxValid,
  input  logic             TxReady,
  output logic             TxLast,
  output logic             Busy,
  output logic [7:0]       DropCnt
);

  localparam int NB    = CNT_W / 8;
  localparam int NBODY = 2 * NB;
  localparam int IDX_W = (NBODY > 1) ? $clog2(NBODY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBODY - 1);

  typedef enum logic [1:0] {IDLE, HDR, BODY, CSUM} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   s0_q, s0_d;
  logic [CNT_W-1:0]   s1_q, s1_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         drop_q, drop_d;

  logic               accept;
  logic [2*CNT_W-1:0] frame_body;
  logic [7:0]         body_byte;

  // Body index 0 is the MSB of S0; the last index is the LSB of S1.
  assign frame_body = {s0_q, s1_q};
  assign body_byte  = 8'(frame_body >> {LAST_IDX - idx_q, 3'b000});

  assign TxValid = (state_q != IDLE);
  assign Busy    = TxValid;
  assign accept  = TxValid && TxReady;
  assign DropCnt = drop_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      s0_q    <= '0;
      s1_q    <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    TxData  = 8'h00;
    TxLast  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Snap) begin
          s0_d    = Cnt0;
          s1_d    = Cnt1;
          csum_d  = 8'h00;
          state_d = HDR;
        end
      end
      HDR: begin
        TxData = HDR_BYTE;
        if (accept) begin
          csum_d  = csum_q ^ HDR_BYTE;
          idx_d   = '0;
          state_d = BODY;
        end
      end
      BODY: begin
        TxData = body_byte;
        if (accept) begin
          csum_d = csum_q ^ body_byte;
          if (idx_q == LAST_IDX) state_d = CSUM;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      CSUM: begin
        TxData = csum_q;
        TxLast = 1'b1;
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Any Snap seen outside IDLE is dropped, including the checksum-accept cycle.
  always_comb begin
    drop_d = drop_q;
    if (Snap && (state_q != IDLE) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

endmodule
